// File: rtl/regfile_wr_arbiter_if.sv
// Register-file write arbiter bus.
// Groups the pipeline writeback request, the multicycle-unit request/ready pair and the
// arbitrated register-file write port with its pending/stall status.
//   master : the pipeline/multicycle side (drives requests, observes port and status)
//   slave  : the arbiter (consumes requests, drives the write port and status)
interface regfile_wr_arbiter_if;
    logic        p_we;
    logic [3:0]  p_dest;
    logic [31:0] p_data;
    logic        m_valid;
    logic [3:0]  m_dest;
    logic [31:0] m_data;
    logic        m_ready;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_data;
    logic [14:0] pending;
    logic        pipe_stall;

    modport master (
        output p_we, p_dest, p_data, m_valid, m_dest, m_data,
        input  m_ready, wb_en, wb_dest, wb_data, pending, pipe_stall
    );

    modport slave (
        input  p_we, p_dest, p_data, m_valid, m_dest, m_data,
        output m_ready, wb_en, wb_dest, wb_data, pending, pipe_stall
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Register-file write arbiter.
// Shares the single 15-entry register-file write port between the pipeline writeback
// (fixed priority, no backpressure) and a multicycle unit whose writes are buffered in a
// FIFO_DEPTH-entry FIFO. A pipe write to register d kills every older buffered write to d;
// killed entries still drain in order, using an idle port cycle with wb_en=0.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : regfile_wr_arbiter_if.slave (requests in, write port/pending/pipe_stall out)
// Optional feature: define WR_ARB_STALL_EN to age a live FIFO head that keeps losing to
// the pipe and raise pipe_stall once it has waited STALL_LIMIT cycles.
module regfile_wr_arbiter #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned STALL_LIMIT = 4
) (
    input logic                   clk,
    input logic                   rst,
    regfile_wr_arbiter_if.slave   bus
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [3:0]          dest_q [FIFO_DEPTH];
    logic [31:0]         data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] live_q;
    logic [PtrW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]     count_q;

    logic p_req, empty, full, accept, push, pop, head_live;
    logic [15:0] pend_all;

    always_comb begin
        p_req     = bus.p_we && (bus.p_dest != 4'd15);
        empty     = (count_q == '0);
        full      = (count_q == CntW'(FIFO_DEPTH));
        // Ready depends on state only; a full FIFO never takes a same-edge push.
        bus.m_ready = !rst && !full;
        accept    = bus.m_valid && bus.m_ready;
        push      = accept && (bus.m_dest != 4'd15);
        pop       = !rst && !p_req && !empty;
        head_live = !empty && live_q[rd_ptr_q];

        bus.wb_en   = 1'b0;
        bus.wb_dest = 4'd0;
        bus.wb_data = 32'd0;
        if (!rst) begin
            if (p_req) begin
                bus.wb_en   = 1'b1;
                bus.wb_dest = bus.p_dest;
                bus.wb_data = bus.p_data;
            end else if (!empty) begin
                bus.wb_en   = live_q[rd_ptr_q];
                bus.wb_dest = dest_q[rd_ptr_q];
                bus.wb_data = data_q[rd_ptr_q];
            end
        end

        // Slots outside the occupied window are always dead, so scanning all is safe.
        pend_all = '0;
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (live_q[i]) pend_all[dest_q[i]] = 1'b1;
        end
        bus.pending = rst ? 15'd0 : pend_all[14:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                dest_q[i] <= 4'd0;
                data_q[i] <= 32'd0;
            end
        end else begin
            // Squash first; a push at this same edge is younger and overrides it below.
            if (p_req) begin
                for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                    if (dest_q[i] == bus.p_dest) live_q[i] <= 1'b0;
                end
            end
            if (pop) begin
                live_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q         <= rd_ptr_q + 1'b1;
            end
            if (push) begin
                dest_q[wr_ptr_q] <= bus.m_dest;
                data_q[wr_ptr_q] <= bus.m_data;
                live_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef WR_ARB_STALL_EN
    localparam int unsigned AgeW = $clog2(STALL_LIMIT + 1);

    logic [AgeW-1:0] age_q, age_d;
    logic            stall_q, stall_d;
    logic            head_squash;

    always_comb begin
        head_squash = p_req && head_live && (dest_q[rd_ptr_q] == bus.p_dest);
        age_d       = age_q;
        if (pop || head_squash) begin
            age_d = '0;
        end else if (p_req && head_live && (age_q != AgeW'(STALL_LIMIT))) begin
            age_d = age_q + 1'b1;
        end
        // Once raised, the request holds until the head actually leaves the FIFO.
        stall_d = !pop && (stall_q || (age_d >= AgeW'(STALL_LIMIT)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            age_q   <= age_d;
            stall_q <= stall_d;
        end
    end

    assign bus.pipe_stall = stall_q;
`else
    assign bus.pipe_stall = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;
`ifdef WR_ARB_STALL_EN
    localparam bit StallEn = 1'b1;
`else
    localparam bit StallEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if bus ();

    regfile_wr_arbiter #(
        .FIFO_DEPTH (4),
        .STALL_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic        p_we;
        logic [3:0]  p_dest;
        logic [31:0] p_data;
        logic        m_valid;
        logic [3:0]  m_dest;
        logic [31:0] m_data;
        logic        e_wb_en;
        logic [3:0]  e_wb_dest;
        logic [31:0] e_wb_data;
        logic        e_m_ready;
        logic [14:0] e_pending;
    } vec_t;

    vec_t vecs [14];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pwe, input logic [3:0] pd, input logic [31:0] pdat,
                         input logic mv, input logic [3:0] md, input logic [31:0] mdat);
        bus.p_we    = pwe;
        bus.p_dest  = pd;
        bus.p_data  = pdat;
        bus.m_valid = mv;
        bus.m_dest  = md;
        bus.m_data  = mdat;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string name, input logic en, input logic [3:0] d,
                          input logic [31:0] dat);
        chk({name, ".wb_en"}, 32'(bus.wb_en), 32'(en));
        chk({name, ".wb_dest"}, 32'(bus.wb_dest), 32'(d));
        chk({name, ".wb_data"}, bus.wb_data, dat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // inputs, then expected wb_en/dest/data, m_ready, pending
        vecs[0]  = '{1'b1, 4'd3,  32'hAA, 1'b0, 4'd0,  32'h0,  1'b1, 4'd3, 32'hAA, 1'b1, 15'h0000};
        vecs[1]  = '{1'b0, 4'd0,  32'h0,  1'b1, 4'd5,  32'h55, 1'b0, 4'd0, 32'h0,  1'b1, 15'h0000};
        vecs[2]  = '{1'b0, 4'd0,  32'h0,  1'b0, 4'd0,  32'h0,  1'b1, 4'd5, 32'h55, 1'b1, 15'h0020};
        vecs[3]  = '{1'b0, 4'd0,  32'h0,  1'b0, 4'd0,  32'h0,  1'b0, 4'd0, 32'h0,  1'b1, 15'h0000};
        vecs[4]  = '{1'b0, 4'd0,  32'h0,  1'b1, 4'd15, 32'h77, 1'b0, 4'd0, 32'h0,  1'b1, 15'h0000};
        vecs[5]  = '{1'b0, 4'd0,  32'h0,  1'b0, 4'd0,  32'h0,  1'b0, 4'd0, 32'h0,  1'b1, 15'h0000};
        vecs[6]  = '{1'b1, 4'd15, 32'h99, 1'b0, 4'd0,  32'h0,  1'b0, 4'd0, 32'h0,  1'b1, 15'h0000};
        vecs[7]  = '{1'b1, 4'd1,  32'h11, 1'b1, 4'd2,  32'h22, 1'b1, 4'd1, 32'h11, 1'b1, 15'h0000};
        vecs[8]  = '{1'b1, 4'd2,  32'h33, 1'b0, 4'd0,  32'h0,  1'b1, 4'd2, 32'h33, 1'b1, 15'h0004};
        vecs[9]  = '{1'b0, 4'd0,  32'h0,  1'b0, 4'd0,  32'h0,  1'b0, 4'd2, 32'h22, 1'b1, 15'h0000};
        vecs[10] = '{1'b0, 4'd0,  32'h0,  1'b0, 4'd0,  32'h0,  1'b0, 4'd0, 32'h0,  1'b1, 15'h0000};
        vecs[11] = '{1'b1, 4'd4,  32'h44, 1'b1, 4'd4,  32'h45, 1'b1, 4'd4, 32'h44, 1'b1, 15'h0000};
        vecs[12] = '{1'b0, 4'd0,  32'h0,  1'b0, 4'd0,  32'h0,  1'b1, 4'd4, 32'h45, 1'b1, 15'h0010};
        vecs[13] = '{1'b0, 4'd0,  32'h0,  1'b0, 4'd0,  32'h0,  1'b0, 4'd0, 32'h0,  1'b1, 15'h0000};

        // Reset holds the outputs quiet even with requests present.
        drive(1'b1, 4'd3, 32'hAA, 1'b1, 4'd5, 32'h55);
        #2;
        chk("rst.wb_en", 32'(bus.wb_en), 32'd0);
        chk("rst.m_ready", 32'(bus.m_ready), 32'd0);
        chk("rst.pending", 32'(bus.pending), 32'd0);
        chk("rst.pipe_stall", 32'(bus.pipe_stall), 32'd0);
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].p_we, vecs[i].p_dest, vecs[i].p_data,
                  vecs[i].m_valid, vecs[i].m_dest, vecs[i].m_data);
            #2;
            chk_wb($sformatf("vec%0d", i), vecs[i].e_wb_en, vecs[i].e_wb_dest, vecs[i].e_wb_data);
            chk($sformatf("vec%0d.m_ready", i), 32'(bus.m_ready), 32'(vecs[i].e_m_ready));
            chk($sformatf("vec%0d.pending", i), 32'(bus.pending), 32'(vecs[i].e_pending));
            step();
        end

        // Fill the FIFO behind a busy pipe, then drain in order.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 4'd1, 32'(k), 1'b1, 4'(8 + k), 32'h80 + 32'(k));
            #2;
            chk($sformatf("fill%0d.m_ready", k), 32'(bus.m_ready), (k < 4) ? 32'd1 : 32'd0);
            chk_wb($sformatf("fill%0d", k), 1'b1, 4'd1, 32'(k));
            step();
        end
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        #2;
        chk("fill.pending", 32'(bus.pending), 32'h0F00);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk_wb($sformatf("drain%0d", k), 1'b1, 4'(8 + k), 32'h80 + 32'(k));
            chk($sformatf("drain%0d.m_ready", k), 32'(bus.m_ready), (k == 0) ? 32'd0 : 32'd1);
            step();
        end
        #2;
        chk_wb("drain_end", 1'b0, 4'd0, 32'h0);

        // Explicit squash case: r7=1 buffered, pipe writes r7=2.
        step();
        drive(1'b1, 4'd0, 32'h5, 1'b1, 4'd7, 32'h1);
        step();
        drive(1'b1, 4'd7, 32'h2, 1'b0, 4'd0, 32'h0);
        #2;
        chk("sq.pending_live", 32'(bus.pending), 32'h0080);
        chk_wb("sq.pipe", 1'b1, 4'd7, 32'h2);
        step();
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        #2;
        chk("sq.pending_clr", 32'(bus.pending), 32'h0000);
        chk("sq.drain_en", 32'(bus.wb_en), 32'd0);
        step();
        #2;
        chk("sq.no_r7", 32'(bus.wb_en), 32'd0);

        // Head aging behind continuous pipe writes.
        step();
        drive(1'b1, 4'd1, 32'h0, 1'b1, 4'd6, 32'h66);
        #2;
        chk("age0.stall", 32'(bus.pipe_stall), 32'd0);
        step();
        for (int c = 1; c <= 5; c++) begin
            drive(1'b1, 4'd1, 32'(c), 1'b0, 4'd0, 32'h0);
            #2;
            chk($sformatf("age%0d.stall", c), 32'(bus.pipe_stall),
                32'(StallEn && (c == 5)));
            chk_wb($sformatf("age%0d", c), 1'b1, 4'd1, 32'(c));
            step();
        end
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        #2;
        chk_wb("age.pop", 1'b1, 4'd6, 32'h66);
        chk("age.pop.stall", 32'(bus.pipe_stall), 32'(StallEn));
        step();
        #2;
        chk("age.after.stall", 32'(bus.pipe_stall), 32'd0);

        // Reset with three writes queued.
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'd1, 32'h0, 1'b1, 4'(9 + k), 32'h90 + 32'(k));
            step();
        end
        drive(1'b1, 4'd1, 32'h0, 1'b1, 4'd12, 32'h93);
        #2;
        chk("q3.pending", 32'(bus.pending), 32'h0E00);
        rst = 1'b1;
        #1;
        chk("rstq.pending", 32'(bus.pending), 32'd0);
        chk("rstq.m_ready", 32'(bus.m_ready), 32'd0);
        chk("rstq.wb_en", 32'(bus.wb_en), 32'd0);
        step();
        rst = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("post%0d.wb_en", k), 32'(bus.wb_en), 32'd0);
            chk($sformatf("post%0d.pending", k), 32'(bus.pending), 32'd0);
            step();
        end
        drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 32'hF0);
        #2;
        chk("r15.m_ready", 32'(bus.m_ready), 32'd1);
        step();
        drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 32'h33);
        #2;
        chk("r15.wb_en", 32'(bus.wb_en), 32'd0);
        step();
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        #2;
        chk_wb("first_acc", 1'b1, 4'd3, 32'h33);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
